// File: rtl/reg_pair_pkg.sv
// reg_pair_pkg: shared definitions for the reg_pair_arbiter slice.
//   - state_t       : arbiter FSM encoding (3-bit)
//   - REQ_A / REQ_B : requester IDs, also the encoding of the round-robin pointer
//   - DEFAULT_WIDTH : default register/data width
package reg_pair_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_A = 3'd1,
        BUSY_B = 3'd2,
        DONE_A = 3'd3,
        DONE_B = 3'd4
    } state_t;

endpackage

// File: rtl/reg_pair_core.sv
// reg_pair_core: twin WIDTH-bit register storage (R0/R1) with synchronous clear.
// Ports:
//   clk, rst        : clock, synchronous active-high clear
//   we, sel, wdata  : single write port (sel 0 = R0, 1 = R1)
//   rsel, rdata     : combinational read mux (rsel 0 = R0, 1 = R1)
//   q0, q1          : current register contents
module reg_pair_core
    import reg_pair_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             sel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rsel,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1
);

    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;

    // Clear has priority so an access cut short by reset never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0 <= '0;
            r1 <= '0;
        end else if (we) begin
            if (sel) r1 <= wdata;
            else     r0 <= wdata;
        end
    end

    assign rdata = rsel ? r1 : r0;
    assign q0    = r0;
    assign q1    = r1;

endmodule

// File: rtl/reg_pair_arbiter.sv
// reg_pair_arbiter: shares the R0/R1 register pair between requesters A and B.
// Each access runs IDLE -> BUSY_x (grant) -> DONE_x (ack) -> IDLE.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_x, we_x, sel_x, wdata_x   : requester x transaction (x = a, b)
//   grant_x                       : requester x is being served
//   ack_x                         : one-cycle completion pulse
//   rdata_x                       : result of x's last transaction, held until next ack
//   q0, q1                        : current R0/R1 for the downstream datapath
//   busy                          : FSM not in IDLE
// Build option: ARB_FIXED_PRIO_EN -- A always wins simultaneous requests and the
// round-robin pointer is not built (B may be starved).
//
// state  | meaning
// IDLE   | waiting for a request; arbitration happens here
// BUSY_A | serving A; register access at the closing edge
// BUSY_B | serving B; register access at the closing edge
// DONE_A | ack_a pulse
// DONE_B | ack_b pulse
module reg_pair_arbiter
    import reg_pair_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             we_a,
    input  logic             sel_a,
    input  logic [WIDTH-1:0] wdata_a,
    output logic             grant_a,
    output logic             ack_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             req_b,
    input  logic             we_b,
    input  logic             sel_b,
    input  logic [WIDTH-1:0] wdata_b,
    output logic             grant_b,
    output logic             ack_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic             pick_b;
    logic             serve_b;
    logic             core_we;
    logic             core_sel;
    logic [WIDTH-1:0] core_wdata;
    logic [WIDTH-1:0] core_rdata;

`ifndef ARB_FIXED_PRIO_EN
    logic rr;

    // Pointer names who wins the next tie; flips to the other side after each service.
    always_ff @(posedge clk) begin
        if (rst)                     rr <= REQ_A;
        else if (state == BUSY_A)    rr <= REQ_B;
        else if (state == BUSY_B)    rr <= REQ_A;
    end
`endif

    always_comb begin
        state_nxt = state;
`ifdef ARB_FIXED_PRIO_EN
        pick_b = req_b && !req_a;
`else
        pick_b = req_b && (!req_a || rr == REQ_B);
`endif
        case (state)
            IDLE:    if (req_a || req_b) state_nxt = pick_b ? BUSY_B : BUSY_A;
            BUSY_A:  state_nxt = DONE_A;
            BUSY_B:  state_nxt = DONE_B;
            DONE_A:  state_nxt = IDLE;
            DONE_B:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The core port is steered to whichever requester holds the grant.
    assign serve_b    = (state == BUSY_B);
    assign core_we    = ((state == BUSY_A) && we_a) || (serve_b && we_b);
    assign core_sel   = serve_b ? sel_b : sel_a;
    assign core_wdata = serve_b ? wdata_b : wdata_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            state <= state_nxt;
            if (state == BUSY_A) rdata_a <= we_a ? wdata_a : core_rdata;
            if (state == BUSY_B) rdata_b <= we_b ? wdata_b : core_rdata;
        end
    end

    reg_pair_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .we    (core_we),
        .sel   (core_sel),
        .wdata (core_wdata),
        .rsel  (core_sel),
        .rdata (core_rdata),
        .q0    (q0),
        .q1    (q1)
    );

    assign grant_a = (state == BUSY_A);
    assign grant_b = (state == BUSY_B);
    assign ack_a   = (state == DONE_A);
    assign ack_b   = (state == DONE_B);
    assign busy    = (state != IDLE);

endmodule
